// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the 32-bit execute ALU.
// Captures decoded operands and control, derives the 4-bit ALU select,
// applies EX/MEM and MEM/WB forwarding to the ALU operands and store data,
// and inserts one bubble per load-use hazard.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic [RA_W-1:0] rd_addr,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            alu_src,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] A_in,
    output logic [XLEN-1:0] B_in,
    output logic [3:0]      ALU_Sel,
    output logic [XLEN-1:0] store_data,
    output logic            out_valid,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [RA_W-1:0] out_rd,
    output logic            hazard_stall
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Stage registers
    logic            valid_q;
    logic            reg_write_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic            alu_src_q;
    logic [RA_W-1:0] rd_q;
    logic [RA_W-1:0] rs1_addr_q;
    logic [RA_W-1:0] rs2_addr_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [3:0]      alu_sel_q;
    logic [3:0]      alu_sel_d;

    logic            load_bubble;
    logic            load_capture;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // Load-use: the load in EX produces its value too late for the next instruction.
    assign hazard_stall = valid_q & mem_read_q & (rd_q != '0) & in_valid &
                          ((rd_q == rs1_addr) | (rd_q == rs2_addr));

    // Flush beats stall; stall masks the hazard and an empty decode slot.
    assign load_bubble  = flush | (~stall & (hazard_stall | ~in_valid));
    assign load_capture = ~flush & ~stall & ~hazard_stall & in_valid;

    // Decode the ALU select from alu_op, funct3 and funct7[5].
    always_comb begin
        // NOTE: default first so every path assigns alu_sel_d and no latch is inferred.
        alu_sel_d = ALU_ADD;
        unique case (alu_op)
            2'b00: alu_sel_d = ALU_ADD;
            2'b01: alu_sel_d = ALU_SUB;
            default: begin
                unique case (funct3)
                    3'b000:  alu_sel_d = (alu_op == 2'b10 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_sel_d = ALU_AND;
                    3'b110:  alu_sel_d = ALU_OR;
                    3'b010:  alu_sel_d = ALU_SLT;
                    default: alu_sel_d = ALU_ADD;
                endcase
            end
        endcase
    end

    // Pick the youngest in-flight producer of a source register; x0 is never forwarded.
    function automatic logic [XLEN-1:0] forward(input logic [RA_W-1:0] addr,
                                                input logic [XLEN-1:0] data);
        if (exmem_reg_write && exmem_rd == addr && addr != '0)
            return exmem_result;
        else if (memwb_reg_write && memwb_rd == addr && addr != '0)
            return memwb_result;
        else
            return data;
    endfunction

    // Forwarded operands and store data.
    always_comb begin
        rs1_fwd    = forward(rs1_addr_q, rs1_data_q);
        rs2_fwd    = forward(rs2_addr_q, rs2_data_q);
        A_in       = rs1_fwd;
        B_in       = alu_src_q ? imm_q : rs2_fwd;
        store_data = rs2_fwd;
    end

    // Stage update: reset or bubble clears everything, capture loads, otherwise hold.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and also clears the data fields, so a bubble
        // presents zero operands rather than stale ones.
        if (rst || load_bubble) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            rd_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_sel_q   <= ALU_ADD;
        end else if (load_capture) begin
            valid_q     <= 1'b1;
            reg_write_q <= reg_write;
            mem_read_q  <= mem_read;
            mem_write_q <= mem_write;
            alu_src_q   <= alu_src;
            rd_q        <= rd_addr;
            rs1_addr_q  <= rs1_addr;
            rs2_addr_q  <= rs2_addr;
            rs1_data_q  <= rs1_data;
            rs2_data_q  <= rs2_data;
            imm_q       <= imm;
            alu_sel_q   <= alu_sel_d;
        end
    end

    assign ALU_Sel       = alu_sel_q;
    assign out_valid     = valid_q;
    assign out_reg_write = reg_write_q;
    assign out_mem_read  = mem_read_q;
    assign out_mem_write = mem_write_q;
    assign out_rd        = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode vector table, directed
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;

    logic        clk;
    logic        rst, in_valid, stall, flush;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5, alu_src, reg_write, mem_read, mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] A_in, B_in, store_data;
    logic [3:0]  ALU_Sel;
    logic        out_valid, out_reg_write, out_mem_read, out_mem_write, hazard_stall;
    logic [4:0]  out_rd;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .alu_src(alu_src),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .A_in(A_in), .B_in(B_in), .ALU_Sel(ALU_Sel), .store_data(store_data),
        .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_rd(out_rd), .hazard_stall(hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid, rw, mr, mw, src;
        logic [4:0]  rd, rs1a, rs2a;
        logic [31:0] rs1d, rs2d, imm;
        logic [3:0]  sel;
    } st_t;

    st_t m, nxt;

    function automatic st_t bubble_st();
        st_t b;
        b = '{valid: 0, rw: 0, mr: 0, mw: 0, src: 0, rd: 0, rs1a: 0, rs2a: 0,
              rs1d: 0, rs2d: 0, imm: 0, sel: 4'b0010};
        return b;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f7);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (f3 == 3'b000) return (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        if (f3 == 3'b010) return 4'b0111;
        return 4'b0010;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
        if (a == 0) return d;
        if (exmem_reg_write && exmem_rd == a) return exmem_result;
        if (memwb_reg_write && memwb_rd == a) return memwb_result;
        return d;
    endfunction

    function automatic logic ref_hazard();
        return m.valid && m.mr && m.rd != 0 && in_valid &&
               (m.rd == rs1_addr || m.rd == rs2_addr);
    endfunction

    function automatic st_t ref_next();
        st_t c;
        if (rst || flush) return bubble_st();
        if (stall) return m;
        if (ref_hazard() || !in_valid) return bubble_st();
        c.valid = 1; c.rw = reg_write; c.mr = mem_read; c.mw = mem_write; c.src = alu_src;
        c.rd = rd_addr; c.rs1a = rs1_addr; c.rs2a = rs2_addr;
        c.rs1d = rs1_data; c.rs2d = rs2_data; c.imm = imm;
        c.sel = ref_sel(alu_op, funct3, funct7_5);
        return c;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] s;
        s = ref_fwd(m.rs2a, m.rs2d);
        check("out_valid", 32'(out_valid), 32'(m.valid));
        check("out_reg_write", 32'(out_reg_write), 32'(m.rw));
        check("out_mem_read", 32'(out_mem_read), 32'(m.mr));
        check("out_mem_write", 32'(out_mem_write), 32'(m.mw));
        check("out_rd", 32'(out_rd), 32'(m.rd));
        check("ALU_Sel", 32'(ALU_Sel), 32'(m.sel));
        check("A_in", A_in, ref_fwd(m.rs1a, m.rs1d));
        check("B_in", B_in, m.src ? m.imm : s);
        check("store_data", store_data, s);
        check("hazard_stall", 32'(hazard_stall), 32'(ref_hazard()));
    endtask

    // Inputs are set at the falling edge; check, advance one rising edge, return at next fall.
    task automatic step();
        #1;
        if (chk_en) check_model();
        nxt = ref_next();
        @(posedge clk);
        m = nxt;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0; in_valid = 0; stall = 0; flush = 0;
        rs1_data = 0; rs2_data = 0; imm = 0;
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
        alu_op = 0; funct3 = 0; funct7_5 = 0; alu_src = 0;
        reg_write = 0; mem_read = 0; mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic rand_inputs();
        rst = ($urandom_range(0, 99) < 2);
        stall = ($urandom_range(0, 99) < 15);
        flush = ($urandom_range(0, 99) < 8);
        in_valid = ($urandom_range(0, 99) < 85);
        rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
        rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
        rd_addr = 5'($urandom_range(0, 7));
        alu_op = 2'($urandom_range(0, 3)); funct3 = 3'($urandom_range(0, 7));
        funct7_5 = 1'($urandom_range(0, 1)); alu_src = 1'($urandom_range(0, 1));
        reg_write = 1'($urandom_range(0, 1));
        mem_read = ($urandom_range(0, 99) < 40);
        mem_write = 1'($urandom_range(0, 1));
        exmem_reg_write = 1'($urandom_range(0, 1)); exmem_rd = 5'($urandom_range(0, 7));
        exmem_result = $urandom;
        memwb_reg_write = 1'($urandom_range(0, 1)); memwb_rd = 5'($urandom_range(0, 7));
        memwb_result = $urandom;
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        src;
        logic [31:0] imm, r1, r2;
        logic [3:0]  exp_sel;
        logic [31:0] exp_a, exp_b;
    } dvec_t;

    dvec_t dv[12];

    initial begin
        dv[0]  = '{2'b10, 3'b000, 1, 0, 0, 7, 3, 4'b0110, 7, 3};
        dv[1]  = '{2'b11, 3'b000, 1, 1, 5, 7, 3, 4'b0010, 7, 5};
        dv[2]  = '{2'b10, 3'b111, 0, 0, 0, 8, 9, 4'b0000, 8, 9};
        dv[3]  = '{2'b10, 3'b110, 1, 0, 0, 1, 2, 4'b0001, 1, 2};
        dv[4]  = '{2'b10, 3'b010, 0, 0, 0, 4, 6, 4'b0111, 4, 6};
        dv[5]  = '{2'b10, 3'b000, 0, 0, 0, 9, 1, 4'b0010, 9, 1};
        dv[6]  = '{2'b10, 3'b001, 1, 0, 0, 3, 3, 4'b0010, 3, 3};
        dv[7]  = '{2'b11, 3'b111, 0, 1, 32'hF0, 2, 2, 4'b0000, 2, 32'hF0};
        dv[8]  = '{2'b11, 3'b110, 1, 1, 32'h11, 2, 2, 4'b0001, 2, 32'h11};
        dv[9]  = '{2'b11, 3'b010, 0, 1, 32'h22, 2, 2, 4'b0111, 2, 32'h22};
        dv[10] = '{2'b00, 3'b111, 1, 1, 32'h40, 5, 6, 4'b0010, 5, 32'h40};
        dv[11] = '{2'b01, 3'b111, 0, 0, 0, 5, 6, 4'b0110, 5, 6};
    end

    // ---------------- main sequence ----------------
    initial begin
        clear_inputs();
        m = bubble_st();
        @(negedge clk);

        // Reset for two cycles with random inputs.
        rand_inputs(); rst = 1;
        step();
        chk_en = 1;
        rand_inputs(); rst = 1;
        step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_sel", 32'(ALU_Sel), 32'b0010);
        rand_inputs(); rst = 0; stall = 0; flush = 0;
        #1 check("rst_hazard", 32'(hazard_stall), 0);
        clear_inputs();

        // Decode sweep.
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            in_valid = 1; alu_op = dv[i].op; funct3 = dv[i].f3; funct7_5 = dv[i].f7;
            alu_src = dv[i].src; imm = dv[i].imm; rs1_data = dv[i].r1; rs2_data = dv[i].r2;
            step();
            check($sformatf("dec%0d_sel", i), 32'(ALU_Sel), 32'(dv[i].exp_sel));
            check($sformatf("dec%0d_a", i), A_in, dv[i].exp_a);
            check($sformatf("dec%0d_b", i), B_in, dv[i].exp_b);
            check($sformatf("dec%0d_valid", i), 32'(out_valid), 1);
        end

        // Forwarding priority and x0.
        clear_inputs();
        in_valid = 1; rs1_addr = 5; rs1_data = 32'h11;
        step();
        clear_inputs();
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAAAA0000;
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h1234;
        #1 check("fwd_exmem", A_in, 32'hAAAA0000);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", A_in, 32'h1234);
        clear_inputs();
        in_valid = 1; rs1_addr = 0; rs1_data = 32'h55;
        step();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hBEEF;
        #1 check("fwd_x0", A_in, 32'h55);
        step();

        // Load-use: lw x6 then consumer of x6 on rs2.
        clear_inputs();
        in_valid = 1; alu_op = 0; mem_read = 1; reg_write = 1; rd_addr = 6; alu_src = 1;
        step();
        clear_inputs();
        in_valid = 1; alu_op = 2'b10; rs2_addr = 6; rd_addr = 7; reg_write = 1;
        #1 check("lu_hazard", 32'(hazard_stall), 1);
        step();
        check("lu_bubble", 32'(out_valid), 0);
        check("lu_rehaz", 32'(hazard_stall), 0);
        step();
        check("lu_capture", 32'(out_valid), 1);
        check("lu_rd", 32'(out_rd), 7);

        // Stall for three cycles with changing inputs: everything frozen.
        clear_inputs();
        in_valid = 1; alu_op = 2'b10; funct3 = 3'b111; rd_addr = 9; reg_write = 1;
        rs1_data = 32'h100; rs2_data = 32'h200;
        step();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            rst = 0; flush = 0; stall = 1; exmem_reg_write = 0; memwb_reg_write = 0;
            step();
            check("stall_sel", 32'(ALU_Sel), 32'b0000);
            check("stall_rd", 32'(out_rd), 9);
            check("stall_a", A_in, 32'h100);
            check("stall_b", B_in, 32'h200);
            check("stall_valid", 32'(out_valid), 1);
        end

        // Flush wins over stall.
        clear_inputs();
        flush = 1; stall = 1; in_valid = 1;
        step();
        check("flush_stall", 32'(out_valid), 0);

        // Load-use while stalled: hold, no bubble.
        clear_inputs();
        in_valid = 1; mem_read = 1; reg_write = 1; rd_addr = 6;
        step();
        clear_inputs();
        in_valid = 1; rs1_addr = 6; stall = 1;
        #1 check("hs_hazard", 32'(hazard_stall), 1);
        step();
        check("hs_valid", 32'(out_valid), 1);
        check("hs_mr", 32'(out_mem_read), 1);
        check("hs_rd", 32'(out_rd), 6);

        // Reset mid-stream.
        rst = 1; stall = 0;
        step();
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_sel", 32'(ALU_Sel), 32'b0010);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
